fft_result_drain: RTL and testbench
===================================

FFT_RESULT_DRAIN -- requirements
Module: fft_result_drain

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning burst-beat index width (burst length 2^N beats).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port n_Reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port i_start, input, 1, drain request pulse (driven by calculation-end).
REQ-006 The block SHALL have port i_samp_number, input, 12, number of result words to drain.
REQ-007 The block SHALL have port o_ram_rd, output, 1, result RAM read strobe.
REQ-008 The block SHALL have port o_ram_addr, output, 12, result RAM word address.
REQ-009 The block SHALL have port i_ram_data, input, 32, RAM read data ({real[31:16], imag[15:0]}), valid exactly 1 cycle after o_ram_rd.
REQ-010 The block SHALL have port o_WDATA, output, 32, write-channel data.
REQ-011 The block SHALL have port o_WVALID, output, 1, write-channel valid.
REQ-012 The block SHALL have port i_WREADY, input, 1, write-channel ready.
REQ-013 The block SHALL have port o_WBURST, output, N, beat index within current burst.
REQ-014 The block SHALL have port o_WLAST, output, 1, last beat of burst or of whole drain.
REQ-015 The block SHALL have port o_busy, output, 1, high in any state other than IDLE.
REQ-016 The block SHALL have port o_done, output, 1, one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, FLUSH, DONE; IDLE->FETCH on i_start with i_samp_number!=0; IDLE->DONE on i_start with i_samp_number==0.
REQ-018 On accepted i_start the block SHALL latch i_samp_number and clear read address, outstanding-read flag, beat counter and transferred-word counter.
REQ-019 In FETCH the block SHALL assert o_ram_rd only when FIFO occupancy plus outstanding reads < DEPTH, incrementing o_ram_addr after each strobe.
REQ-020 FETCH->FLUSH SHALL occur on the cycle the read of address samp_number-1 is issued; no further o_ram_rd in FLUSH.
REQ-021 Read data SHALL be written into the FIFO on the edge following o_ram_rd, first word thus visible on o_WVALID two cycles after the i_start edge.
REQ-022 o_WVALID SHALL equal FIFO-not-empty; o_WDATA SHALL be the FIFO head.
REQ-023 A beat transfers when o_WVALID and i_WREADY are both high at a rising edge; FIFO pops on transfer.
REQ-024 While o_WVALID is high and i_WREADY low, o_WDATA, o_WBURST, o_WLAST SHALL remain stable.
REQ-025 o_WBURST SHALL increment modulo 2^N per transfer and reset to 0 after a word with o_WLAST.
REQ-026 o_WLAST SHALL be high when o_WBURST==2^N-1 or head word is word samp_number-1.
REQ-027 With i_WREADY held high the block SHALL sustain one transfer per cycle with no bubbles.
REQ-028 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; FIFO SHALL never overflow nor pop when empty.
REQ-029 FLUSH->DONE SHALL occur on the transfer of word samp_number-1; DONE asserts o_done for exactly one cycle, then IDLE.
REQ-030 i_start while o_busy SHALL be ignored with no effect on the drain in progress.
REQ-031 Address and counters SHALL be 12 bits; i_samp_number=4095 SHALL drain addresses 0..4094 without wrap.

Reset
REQ-032 While n_Reset is low, all outputs SHALL be 0, FSM in IDLE, FIFO empty, counters 0, independent of clk.
REQ-033 Reset asserted mid-drain SHALL abort immediately; pending FIFO words are discarded and no o_done is produced.
REQ-034 After n_Reset deasserts the block SHALL accept i_start on the first following rising edge.

Verification
REQ-035 i_samp_number=8, N=2, i_WREADY=1, RAM[i]=i*0x00010001 -> 8 beats 0x00000000..0x00070007, o_WBURST 0,1,2,3,0,1,2,3, o_WLAST on beats 3 and 7, o_done 1 cycle after beat 7.
REQ-036 i_samp_number=6, N=2, i_WREADY toggling 1/0 each cycle -> data stable while stalled, o_WLAST on beats 3 and 5, no lost/duplicated words, no more than DEPTH reads outstanding+buffered.
REQ-037 i_samp_number=0, i_start pulse -> no o_ram_rd, no o_WVALID, o_done high on the cycle after the start edge.
REQ-038 i_samp_number=16, i_WREADY=0 for 20 cycles then 1 -> exactly 4 reads issued before stall release, then all 16 words in order.
REQ-039 i_start with i_samp_number=10, second i_start with 3 at beat 4 -> 10 words drained, single o_done.
REQ-040 n_Reset low at beat 5 of 12 -> all outputs 0 immediately, no o_done; new i_start with 2 after release -> words 0,1 drained normally.

Source files
------------

// File: rtl/fft_result_drain.sv
// fft_result_drain: streams FFT result RAM words onto a write
// channel in bursts of 2^N beats through a small prefetch FIFO.
module fft_result_drain #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         n_Reset,
  input  logic         i_start,
  input  logic [11:0]  i_samp_number,
  output logic         o_ram_rd,
  output logic [11:0]  o_ram_addr,
  input  logic [31:0]  i_ram_data,
  output logic [31:0]  o_WDATA,
  output logic         o_WVALID,
  input  logic         i_WREADY,
  output logic [N-1:0] o_WBURST,
  output logic         o_WLAST,
  output logic         o_busy,
  output logic         o_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [11:0]   samp_q, samp_d;
  logic [11:0]   addr_q, addr_d;
  logic [11:0]   xfer_q, xfer_d;
  logic          pend_q, pend_d;
  logic [N-1:0]  burst_q, burst_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] occ;
  logic          valid, fire, rd;
  logic          last_word, last;

  assign valid     = cnt_q != '0;
  assign fire      = valid & i_WREADY;
  // in-flight read counts as occupied so the FIFO can never overflow
  assign occ       = cnt_q + CW'(pend_q);
  assign rd        = (state_q == FETCH) && (occ < DEPTH_C);
  assign last_word = xfer_q == samp_q - 12'd1;
  assign last      = valid & ((&burst_q) | last_word);

  assign o_ram_rd   = rd;
  assign o_ram_addr = addr_q;
  assign o_WDATA    = valid ? mem_q[rptr_q] : '0;
  assign o_WVALID   = valid;
  assign o_WBURST   = burst_q;
  assign o_WLAST    = last;
  assign o_busy     = state_q != IDLE;
  assign o_done     = state_q == DONE;

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    addr_d  = addr_q;
    xfer_d  = xfer_q;
    burst_d = burst_q;
    pend_d  = rd;
    if (fire) begin
      xfer_d  = xfer_q + 12'd1;
      burst_d = last ? '0 : burst_q + N'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          samp_d  = i_samp_number;
          addr_d  = '0;
          pend_d  = 1'b0;
          xfer_d  = '0;
          burst_d = '0;
          state_d = (i_samp_number == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (rd) begin
          addr_d = addr_q + 12'd1;
          if (addr_q == samp_q - 12'd1) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (fire && last_word) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      state_q <= IDLE;
      samp_q  <= '0;
      addr_q  <= '0;
      xfer_q  <= '0;
      burst_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      addr_q  <= addr_d;
      xfer_q  <= xfer_d;
      burst_q <= burst_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (pend_q) wptr_q <= wptr_q + AW'(1);
      if (fire)   rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(pend_q) - CW'(fire);
    end
  end

  // storage needs no reset: o_WDATA is masked while empty
  always_ff @(posedge clk) begin
    if (pend_q) mem_q[wptr_q] <= i_ram_data;
  end

endmodule

// File: tb/tb_fft_result_drain.sv
// tb_fft_result_drain: scoreboard bench for fft_result_drain
// with N=2, DEPTH=4 and a one-cycle-latency RAM model.
module tb_fft_result_drain;

  localparam int NB = 2;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          n_Reset;
  logic          i_start;
  logic [11:0]   i_samp_number;
  logic          o_ram_rd;
  logic [11:0]   o_ram_addr;
  logic [31:0]   i_ram_data;
  logic [31:0]   o_WDATA;
  logic          o_WVALID;
  logic          i_WREADY;
  logic [NB-1:0] o_WBURST;
  logic          o_WLAST;
  logic          o_busy;
  logic          o_done;

  typedef struct {
    logic [31:0]   data;
    logic [NB-1:0] burst;
    logic          last;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int errors = 0;

  fft_result_drain #(.N(NB), .DEPTH(DP)) dut (
    .clk          (clk),
    .n_Reset      (n_Reset),
    .i_start      (i_start),
    .i_samp_number(i_samp_number),
    .o_ram_rd     (o_ram_rd),
    .o_ram_addr   (o_ram_addr),
    .i_ram_data   (i_ram_data),
    .o_WDATA      (o_WDATA),
    .o_WVALID     (o_WVALID),
    .i_WREADY     (i_WREADY),
    .o_WBURST     (o_WBURST),
    .o_WLAST      (o_WLAST),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  // RAM: data valid only in the cycle after the strobe
  always @(posedge clk) begin
    if (o_ram_rd) i_ram_data <= 32'(o_ram_addr) * 32'h0001_0001;
    else          i_ram_data <= 32'hDEAD_BEEF;
  end

  task automatic expect_words(input int n);
    beat_t e;
    int b = 0;
    for (int i = 0; i < n; i++) begin
      e.data  = 32'(i) * 32'h0001_0001;
      e.burst = NB'(b);
      e.last  = (b == 3) || (i == n - 1);
      q.push_back(e);
      b = e.last ? 0 : b + 1;
    end
  endtask

  task automatic start(input logic [11:0] n);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_samp_number = n;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    n_Reset = 1'b0;
    i_start = 1'b1;
    i_samp_number = 12'd5;
    i_WREADY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      outs = {o_ram_rd, o_ram_addr, o_WDATA, o_WVALID,
              o_WBURST, o_WLAST, o_busy, o_done};
      checks++;
      if (outs !== 64'd0) begin
        errors++;
        $display("FAIL reset_outs got %h want 0", outs);
      end
    end
    @(posedge clk); #1;
    n_Reset = 1'b1;
    i_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_busy, o_WVALID, o_ram_rd} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle got %b want 000",
               {o_busy, o_WVALID, o_ram_rd});
    end
  endtask

  task automatic test_basic();
    beat_t e;
    int first = -1, prev = -1, dcyc = -1, dn = 0;
    q.delete();
    expect_words(8);
    i_WREADY = 1'b1;
    start(12'd8);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (o_done) begin dn++; dcyc = c; end
      if (o_WVALID && i_WREADY) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL basic_extra got %h want none", o_WDATA);
        end else begin
          e = q.pop_front();
          if ({o_WDATA, o_WBURST, o_WLAST} !== {e.data, e.burst, e.last}) begin
            errors++;
            $display("FAIL basic_beat got %h/%0d/%b want %h/%0d/%b",
                     o_WDATA, o_WBURST, o_WLAST, e.data, e.burst, e.last);
          end
        end
        if (first < 0) first = c;
        else begin
          checks++;
          if (c != prev + 1) begin
            errors++;
            $display("FAIL basic_bubble got cycle %0d want %0d", c, prev + 1);
          end
        end
        prev = c;
      end
    end
    checks++;
    if (first != 2) begin
      errors++;
      $display("FAIL basic_latency got %0d want 2", first);
    end
    checks++;
    if (dn != 1 || dcyc != prev + 1) begin
      errors++;
      $display("FAIL basic_done got %0d pulses at %0d want 1 at %0d",
               dn, dcyc, prev + 1);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL basic_missing got %0d left want 0", q.size());
    end
  endtask

  task automatic test_stall();
    beat_t e;
    logic [35:0] held;
    logic hold = 1'b0;
    int rds = 0, xf = 0, dn = 0;
    q.delete();
    expect_words(6);
    i_WREADY = 1'b1;
    start(12'd6);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_done) dn++;
      if (hold) begin
        checks++;
        if (!o_WVALID || {o_WDATA, o_WBURST, o_WLAST} !== held) begin
          errors++;
          $display("FAIL stall_stable got %b/%h want 1/%h", o_WVALID,
                   {o_WDATA, o_WBURST, o_WLAST}, held);
        end
      end
      hold = o_WVALID && !i_WREADY;
      held = {o_WDATA, o_WBURST, o_WLAST};
      if (o_ram_rd) rds++;
      if (o_WVALID && i_WREADY) begin
        xf++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stall_extra got %h want none", o_WDATA);
        end else begin
          e = q.pop_front();
          if ({o_WDATA, o_WBURST, o_WLAST} !== {e.data, e.burst, e.last}) begin
            errors++;
            $display("FAIL stall_beat got %h/%0d/%b want %h/%0d/%b",
                     o_WDATA, o_WBURST, o_WLAST, e.data, e.burst, e.last);
          end
        end
      end
      if (rds - xf > DP) begin
        checks++;
        errors++;
        $display("FAIL stall_inflight got %0d want <=%0d", rds - xf, DP);
      end
      @(posedge clk); #1;
      i_WREADY = ~i_WREADY;
    end
    checks++;
    if (dn != 1 || q.size() != 0 || rds != 6) begin
      errors++;
      $display("FAIL stall_end got done=%0d left=%0d rds=%0d want 1/0/6",
               dn, q.size(), rds);
    end
  endtask

  task automatic test_zero();
    i_WREADY = 1'b1;
    start(12'd0);
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done got %b want 1", o_done);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({o_ram_rd, o_WVALID, o_done} !== {2'b00, c == 0}) begin
        errors++;
        $display("FAIL zero_outs c=%0d got %b want %b", c,
                 {o_ram_rd, o_WVALID, o_done}, {2'b00, c == 0});
      end
    end
  endtask

  task automatic test_prefetch();
    beat_t e;
    int rds = 0, dn = 0;
    q.delete();
    expect_words(16);
    i_WREADY = 1'b0;
    start(12'd16);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o_ram_rd) rds++;
      if (o_done) dn++;
      if (o_WVALID && i_WREADY) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL pref_extra got %h want none", o_WDATA);
        end else begin
          e = q.pop_front();
          if ({o_WDATA, o_WBURST, o_WLAST} !== {e.data, e.burst, e.last}) begin
            errors++;
            $display("FAIL pref_beat got %h/%0d/%b want %h/%0d/%b",
                     o_WDATA, o_WBURST, o_WLAST, e.data, e.burst, e.last);
          end
        end
      end
      if (c == 19) begin
        checks++;
        if (rds != DP) begin
          errors++;
          $display("FAIL pref_reads got %0d want %0d", rds, DP);
        end
        @(posedge clk); #1;
        i_WREADY = 1'b1;
      end
    end
    checks++;
    if (dn != 1 || q.size() != 0 || rds != 16) begin
      errors++;
      $display("FAIL pref_end got done=%0d left=%0d rds=%0d want 1/0/16",
               dn, q.size(), rds);
    end
  endtask

  task automatic test_restart();
    beat_t e;
    int xf = 0, dn = 0;
    logic sent = 1'b0;
    q.delete();
    expect_words(10);
    i_WREADY = 1'b1;
    start(12'd10);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_done) dn++;
      if (o_WVALID && i_WREADY) begin
        xf++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL restart_extra got %h want none", o_WDATA);
        end else begin
          e = q.pop_front();
          if ({o_WDATA, o_WBURST, o_WLAST} !== {e.data, e.burst, e.last}) begin
            errors++;
            $display("FAIL restart_beat got %h/%0d/%b want %h/%0d/%b",
                     o_WDATA, o_WBURST, o_WLAST, e.data, e.burst, e.last);
          end
        end
      end
      @(posedge clk); #1;
      i_start = (xf == 4) && !sent;
      i_samp_number = 12'd3;
      if (i_start) sent = 1'b1;
    end
    i_start = 1'b0;
    checks++;
    if (dn != 1 || q.size() != 0 || xf != 10 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_end got done=%0d left=%0d xf=%0d busy=%b want 1/0/10/0",
               dn, q.size(), xf, o_busy);
    end
  endtask

  task automatic test_reset_mid();
    beat_t e;
    logic [63:0] outs;
    int xf = 0, dn = 0;
    q.delete();
    expect_words(12);
    i_WREADY = 1'b1;
    start(12'd12);
    for (int c = 0; c < 30 && xf < 5; c++) begin
      @(negedge clk);
      if (o_WVALID && i_WREADY) begin
        xf++;
        e = q.pop_front();
        checks++;
        if (o_WDATA !== e.data) begin
          errors++;
          $display("FAIL rmid_beat got %h want %h", o_WDATA, e.data);
        end
      end
    end
    @(posedge clk); #1;
    n_Reset = 1'b0;
    #1;
    outs = {o_ram_rd, o_ram_addr, o_WDATA, o_WVALID,
            o_WBURST, o_WLAST, o_busy, o_done};
    checks++;
    if (outs !== 64'd0) begin
      errors++;
      $display("FAIL rmid_outs got %h want 0", outs);
    end
    q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    @(posedge clk); #1;
    n_Reset = 1'b1;
    i_start = 1'b1;
    i_samp_number = 12'd2;
    expect_words(2);
    @(posedge clk); #1;
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_accept got busy=%b want 1", o_busy);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (o_done) dn++;
      if (o_WVALID && i_WREADY) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rmid_extra got %h want none", o_WDATA);
        end else begin
          e = q.pop_front();
          if ({o_WDATA, o_WBURST, o_WLAST} !== {e.data, e.burst, e.last}) begin
            errors++;
            $display("FAIL rmid_beat2 got %h/%0d/%b want %h/%0d/%b",
                     o_WDATA, o_WBURST, o_WLAST, e.data, e.burst, e.last);
          end
        end
      end
    end
    checks++;
    if (dn != 1 || q.size() != 0) begin
      errors++;
      $display("FAIL rmid_end got done=%0d left=%0d want 1/0", dn, q.size());
    end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    int lens[3] = '{5, 7, 1};
    int dn;
    logic [35:0] held;
    logic hold;
    for (int t = 0; t < 3; t++) begin
      q.delete();
      expect_words(lens[t]);
      dn = 0;
      hold = 1'b0;
      i_WREADY = 1'($urandom_range(0, 1));
      start(12'(lens[t]));
      for (int c = 0; c < 80 && dn == 0; c++) begin
        @(negedge clk);
        if (o_done) dn++;
        if (hold) begin
          checks++;
          if ({o_WDATA, o_WBURST, o_WLAST} !== held) begin
            errors++;
            $display("FAIL b2b_stable got %h want %h",
                     {o_WDATA, o_WBURST, o_WLAST}, held);
          end
        end
        hold = o_WVALID && !i_WREADY;
        held = {o_WDATA, o_WBURST, o_WLAST};
        if (o_WVALID && i_WREADY) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL b2b_extra got %h want none", o_WDATA);
          end else begin
            e = q.pop_front();
            if ({o_WDATA, o_WBURST, o_WLAST} !== {e.data, e.burst, e.last}) begin
              errors++;
              $display("FAIL b2b_beat got %h/%0d/%b want %h/%0d/%b",
                       o_WDATA, o_WBURST, o_WLAST, e.data, e.burst, e.last);
            end
          end
        end
        if (dn == 0) begin
          @(posedge clk); #1;
          i_WREADY = 1'($urandom_range(0, 1));
        end
      end
      checks++;
      if (dn != 1 || q.size() != 0) begin
        errors++;
        $display("FAIL b2b_end len=%0d got done=%0d left=%0d want 1/0",
                 lens[t], dn, q.size());
      end
    end
  endtask

  task automatic test_max();
    beat_t e;
    int rds = 0, dn = 0;
    logic [11:0] maxa = '0;
    q.delete();
    expect_words(4095);
    i_WREADY = 1'b1;
    start(12'd4095);
    for (int c = 0; c < 4200; c++) begin
      @(negedge clk);
      if (o_done) dn++;
      if (o_ram_rd) begin
        rds++;
        if (o_ram_addr > maxa) maxa = o_ram_addr;
      end
      if (o_WVALID && i_WREADY) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL max_extra got %h want none", o_WDATA);
        end else begin
          e = q.pop_front();
          if ({o_WDATA, o_WBURST, o_WLAST} !== {e.data, e.burst, e.last}) begin
            errors++;
            $display("FAIL max_beat got %h/%0d/%b want %h/%0d/%b",
                     o_WDATA, o_WBURST, o_WLAST, e.data, e.burst, e.last);
          end
        end
      end
    end
    checks++;
    if (dn != 1 || q.size() != 0 || rds != 4095 || maxa != 12'd4094) begin
      errors++;
      $display("FAIL max_end got done=%0d left=%0d rds=%0d maxa=%0d want 1/0/4095/4094",
               dn, q.size(), rds, maxa);
    end
  endtask

  initial begin
    n_Reset = 1'b0;
    i_start = 1'b0;
    i_samp_number = '0;
    i_WREADY = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_prefetch();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
